// File: rtl/layer_accumulator_pkg.sv
// Shared types and sizing helpers for the spiking-layer accumulator slice.
package layer_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} acc_state_t;

  // Wide enough to sum NEURON_IN sign-extended weights without overflow.
  function automatic int acc_width(input int w_size, input int neurons_in);
    return w_size + $clog2(neurons_in) + 1;
  endfunction

endpackage

// File: rtl/layer_accumulator_if.sv
// Frame-in / ROM / spikes-out signal bundle for layer_accumulator.
interface layer_accumulator_if #(
  parameter int NEURON_IN  = 8,
  parameter int NEURON_OUT = 2,
  parameter int W_SIZE     = 8
);

  logic                         in_valid;
  logic                         in_ready;
  logic [NEURON_IN-1:0]         in_spikes;
  logic [NEURON_IN-1:0]         rom_addr;
  logic [NEURON_OUT*W_SIZE-1:0] rom_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [NEURON_OUT-1:0]        out_spikes;

  // master: the accumulator; slave: upstream source, ROM and downstream sink.
  modport master (
    input  in_valid, in_spikes, rom_data, out_ready,
    output in_ready, rom_addr, out_valid, out_spikes
  );

  modport slave (
    output in_valid, in_spikes, rom_data, out_ready,
    input  in_ready, rom_addr, out_valid, out_spikes
  );

endinterface

// File: rtl/layer_accumulator_neuron_acc.sv
// One output neuron: signed accumulator with clear / enable-add and a firing comparator.
module neuron_acc
  import layer_pkg::*;
#(
  parameter int W_SIZE    = 8,
  parameter int ACC_W     = acc_width(W_SIZE, 8),
  parameter int THRESHOLD = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [W_SIZE-1:0] weight,
  output logic                     fire
);

  localparam logic signed [ACC_W-1:0] THR = ACC_W'(THRESHOLD);

  logic signed [ACC_W-1:0] acc;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [W_SIZE-1:0] w);
    return ACC_W'(w);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + sext(weight);
    end
  end

  assign fire = (acc >= THR);

endmodule

// File: rtl/layer_accumulator.sv
// Walks a latched input-spike frame through rom_layer and thresholds the per-neuron weight sums.
module layer_accumulator
  import layer_pkg::*;
#(
  parameter int NEURON_IN  = 8,
  parameter int NEURON_OUT = 2,
  parameter int W_SIZE     = 8,
  parameter int THRESHOLD  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  layer_accumulator_if.master bus
);

  localparam int ACC_W = acc_width(W_SIZE, NEURON_IN);
  localparam int IDX_W = (NEURON_IN > 1) ? $clog2(NEURON_IN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURON_IN - 1);

  acc_state_t            state;
  logic [IDX_W-1:0]      idx;
  logic [NEURON_IN-1:0]  frame;
  logic                  in_ready_r;
  logic                  out_valid_r;
  logic [NEURON_IN-1:0]  rom_addr_r;
  logic [NEURON_OUT-1:0] out_spikes_r;
  logic [NEURON_OUT-1:0] fire;
  logic                  accept;
  logic                  add_en;

  function automatic logic [NEURON_IN-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NEURON_IN-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign accept = (state == IDLE) && bus.in_valid && in_ready_r;
  assign add_en = (state == SCAN) && frame[idx];

  // rom_addr is registered one step ahead so it always matches idx during SCAN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      frame        <= '0;
      in_ready_r   <= 1'b1;
      rom_addr_r   <= '0;
      out_valid_r  <= 1'b0;
      out_spikes_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            frame      <= bus.in_spikes;
            idx        <= '0;
            in_ready_r <= 1'b0;
            rom_addr_r <= onehot('0);
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (idx == LAST_IDX) begin
            rom_addr_r <= '0;
            state      <= DONE;
          end else begin
            idx        <= idx + 1'b1;
            rom_addr_r <= onehot(idx + 1'b1);
          end
        end
        DONE: begin
          // First DONE cycle captures the settled sums; afterwards hold until taken.
          if (!out_valid_r) begin
            out_valid_r  <= 1'b1;
            out_spikes_r <= fire;
          end else if (bus.out_ready) begin
            out_valid_r  <= 1'b0;
            out_spikes_r <= '0;
            in_ready_r   <= 1'b1;
            idx          <= '0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar j = 0; j < NEURON_OUT; j++) begin : g_neuron
    neuron_acc #(
      .W_SIZE    (W_SIZE),
      .ACC_W     (ACC_W),
      .THRESHOLD (THRESHOLD)
    ) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (accept),
      .en     (add_en),
      .weight (bus.rom_data[j*W_SIZE +: W_SIZE]),
      .fire   (fire[j])
    );
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.rom_addr   = rom_addr_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_spikes = out_spikes_r;

endmodule
